// File: rtl/program_loader.sv
// Boot loader: framed byte stream into instruction/data memory,
// holding the core in reset until a checksum-verified load completes.
module program_loader #(
  parameter int ADDR_W        = 9,
  parameter int DEPTH         = 512,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  localparam int CW = $clog2(RELEASE_DELAY + 1);
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_LOAD,
    S_CSUM, S_RELEASE, S_DONE, S_ERROR
  } state_e;

  state_e state_q, state_d;

  logic [15:0]       length_q, length_d;
  logic [7:0]        sum_q, sum_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]   byte_count_q, byte_count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic        accept;
  logic        start_ok;
  logic [15:0] len_full;
  logic [15:0] bc_next;
  logic        last_byte;

  assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_LOAD)   || (state_q == S_CSUM);
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state_q == S_IDLE) ||
                     (state_q == S_DONE) || (state_q == S_ERROR));
  assign len_full  = {in_data, length_q[7:0]};
  assign bc_next   = 16'(byte_count_q) + 16'd1;
  assign last_byte = (bc_next == length_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      length_q     <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      byte_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      byte_count_q <= byte_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR:
        if (start_ok) state_d = S_LEN_LO;
      S_LEN_LO:
        if (accept) state_d = S_LEN_HI;
      S_LEN_HI:
        if (accept) begin
          if (len_full > DEPTH16)     state_d = S_ERROR;
          else if (len_full == 16'd0) state_d = S_CSUM;
          else                        state_d = S_LOAD;
        end
      S_LOAD:
        if (accept && last_byte) state_d = S_CSUM;
      S_CSUM:
        if (accept) begin
          state_d = (in_data == sum_q) ? S_RELEASE : S_ERROR;
        end
      S_RELEASE:
        // counter reaches zero on this edge
        if (cnt_q <= CW'(1)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    length_d     = length_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    byte_count_d = byte_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if (start_ok) begin
      sum_d        = '0;
      byte_count_d = '0;
      mem_addr_d   = '0;
    end
    if (accept && state_q == S_LEN_LO) length_d[7:0]  = in_data;
    if (accept && state_q == S_LEN_HI) length_d[15:8] = in_data;
    if (accept && state_q == S_LOAD) begin
      mem_we_d     = 1'b1;
      mem_wdata_d  = in_data;
      mem_addr_d   = byte_count_q[ADDR_W-1:0];
      byte_count_d = byte_count_q + 1'b1;
      sum_d        = sum_q + in_data;
    end
    if (accept && state_q == S_CSUM) cnt_d = CW'(RELEASE_DELAY);
    if (state_q == S_RELEASE && cnt_q != '0) cnt_d = cnt_q - CW'(1);
    // status flags follow the next state so they move with it
    cpu_reset_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
    busy_d      = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                  (state_d == S_LOAD)   || (state_d == S_CSUM)   ||
                  (state_d == S_RELEASE);
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign byte_count = byte_count_q;

endmodule
